alu_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one combinational ALU among `NUM_REQ` requesters, such as the integer pipe, the address-generation unit and a debug port. Each request carries an opcode, using the ALU's 5-bit select encoding (0–16), plus operands. The block accepts one request at a time over a valid/ready handshake. It registers the operands onto the ALU inputs, captures the result and returns it to the granted requester over a per-requester response handshake. It sits between the requesters and the ALU instance; the ALU itself is instantiated outside this block.

---
 rtl/alu_arbiter.sv | 205 ++++++++++++++++++++
 tb/tb_alu_arbiter.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin arbiter/sequencer sharing one external combinational
// ALU among NUM_REQ requesters. One operation is in flight at a time:
// IDLE (accept) -> EXEC (ALU settles, result captured) -> RESP (handshake).
// Optional feature macro: ALU_ARB_TIMEOUT_EN adds a RESP watchdog and the
// `timeout` output port.
module alu_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [NUM_REQ*5-1:0]  req_op,
    input  logic [NUM_REQ*32-1:0] req_a,
    input  logic [NUM_REQ*32-1:0] req_b,
    input  logic [NUM_REQ*5-1:0]  req_shamt,
    output logic [NUM_REQ-1:0]    rsp_valid,
    input  logic [NUM_REQ-1:0]    rsp_ready,
    output logic [31:0]           rsp_data,
    output logic                  rsp_err,
    output logic [31:0]           alu_number1,
    output logic [31:0]           alu_number2,
    output logic [4:0]            alu_shamt,
    output logic [4:0]            alu_sel,
    input  logic [31:0]           alu_result
`ifdef ALU_ARB_TIMEOUT_EN
    ,
    output logic                  timeout
`endif
);

    localparam int         IDXW   = $clog2(NUM_REQ);
    localparam logic [4:0] MAX_OP = 5'd16;

    // Reject out-of-range configurations at elaboration time.
    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT < 1) begin : g_param_check
        $error("alu_arbiter: NUM_REQ must be 2..8 and TIMEOUT >= 1");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t              r_state;
    logic [IDXW-1:0]     r_gnt;
    logic [IDXW-1:0]     r_last;
    logic [31:0]         r_number1;
    logic [31:0]         r_number2;
    logic [4:0]          r_shamt;
    logic [4:0]          r_sel;
    logic [NUM_REQ-1:0]  r_rsp_valid;
    logic [31:0]         r_rsp_data;
    logic                r_rsp_err;

    logic                w_grant_any;
    logic [IDXW-1:0]     w_grant_idx;
    logic [IDXW-1:0]     w_cand;
    logic [31:0]         w_scan;
    logic [4:0]          w_op;
    logic [31:0]         w_a;
    logic [31:0]         w_b;
    logic [4:0]          w_sh;
    logic [NUM_REQ-1:0]  w_req_ready;
    logic                w_sel_bad;

`ifdef ALU_ARB_TIMEOUT_EN
    localparam int CNTW = $clog2(TIMEOUT + 1);
    logic [CNTW-1:0]     r_cnt;
    logic                r_timeout;
`endif

    // One-hot decode of a requester index.
    function automatic logic [NUM_REQ-1:0] idx_onehot(input logic [IDXW-1:0] idx);
        logic [NUM_REQ-1:0] v;
        v = {NUM_REQ{1'b0}};
        for (int i = 0; i < NUM_REQ; i++) begin
            v[i] = (IDXW'(i) == idx) ? 1'b1 : 1'b0;
        end
        return v;
    endfunction

    // Round-robin pick: scan backward so the first valid bit after r_last wins.
    always_comb begin
        w_grant_any = 1'b0;
        w_grant_idx = {IDXW{1'b0}};
        w_cand      = {IDXW{1'b0}};
        w_scan      = 32'd0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_scan      = 32'(r_last) + 32'(k) + 32'd1;
            w_scan      = (w_scan >= 32'(NUM_REQ)) ? (w_scan - 32'(NUM_REQ)) : w_scan;
            w_cand      = IDXW'(w_scan);
            w_grant_idx = req_valid[w_cand] ? w_cand : w_grant_idx;
            w_grant_any = w_grant_any | req_valid[w_cand];
        end
    end

    // Select the granted requester's payload.
    always_comb begin
        w_op = 5'd0;
        w_a  = 32'd0;
        w_b  = 32'd0;
        w_sh = 5'd0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_op = (IDXW'(i) == w_grant_idx) ? req_op[i*5 +: 5]     : w_op;
            w_a  = (IDXW'(i) == w_grant_idx) ? req_a[i*32 +: 32]    : w_a;
            w_b  = (IDXW'(i) == w_grant_idx) ? req_b[i*32 +: 32]    : w_b;
            w_sh = (IDXW'(i) == w_grant_idx) ? req_shamt[i*5 +: 5] : w_sh;
        end
    end

    // Accept strobe is combinational in IDLE and forced low while in reset.
    always_comb begin
        w_req_ready = (rst_n && (r_state == S_IDLE) && w_grant_any)
                      ? idx_onehot(w_grant_idx) : {NUM_REQ{1'b0}};
        w_sel_bad   = (r_sel > MAX_OP);
    end

    // Sequencer FSM: accept, execute, respond; all outputs registered here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_gnt       <= {IDXW{1'b0}};
            r_last      <= IDXW'(NUM_REQ - 1);
            r_number1   <= 32'd0;
            r_number2   <= 32'd0;
            r_shamt     <= 5'd0;
            r_sel       <= 5'd0;
            r_rsp_valid <= {NUM_REQ{1'b0}};
            r_rsp_data  <= 32'd0;
            r_rsp_err   <= 1'b0;
`ifdef ALU_ARB_TIMEOUT_EN
            r_cnt       <= {CNTW{1'b0}};
            r_timeout   <= 1'b0;
`endif
        end else begin
`ifdef ALU_ARB_TIMEOUT_EN
            r_timeout <= 1'b0;
`endif
            case (r_state)
                S_IDLE: begin
                    if (w_grant_any) begin
                        r_number1 <= w_a;
                        r_number2 <= w_b;
                        r_shamt   <= w_sh;
                        r_sel     <= w_op;
                        r_gnt     <= w_grant_idx;
                        r_last    <= w_grant_idx;
                        r_state   <= S_EXEC;
                    end else begin
                        r_state   <= S_IDLE;
                    end
                end
                S_EXEC: begin
                    r_rsp_err   <= w_sel_bad;
                    r_rsp_data  <= w_sel_bad ? 32'd0 : alu_result;
                    r_rsp_valid <= idx_onehot(r_gnt);
`ifdef ALU_ARB_TIMEOUT_EN
                    r_cnt       <= {CNTW{1'b0}};
`endif
                    r_state     <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_ready[r_gnt]) begin
                        r_rsp_valid <= {NUM_REQ{1'b0}};
                        r_state     <= S_IDLE;
                    end
`ifdef ALU_ARB_TIMEOUT_EN
                    else if (r_cnt == CNTW'(TIMEOUT - 1)) begin
                        r_rsp_valid <= {NUM_REQ{1'b0}};
                        r_timeout   <= 1'b1;
                        r_state     <= S_IDLE;
                    end else begin
                        r_cnt       <= r_cnt + CNTW'(1);
                        r_state     <= S_RESP;
                    end
`else
                    else begin
                        r_state     <= S_RESP;
                    end
`endif
                end
                default: begin
                    r_rsp_valid <= {NUM_REQ{1'b0}};
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign req_ready   = w_req_ready;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_data    = r_rsp_data;
    assign rsp_err     = r_rsp_err;
    assign alu_number1 = r_number1;
    assign alu_number2 = r_number2;
    assign alu_shamt   = r_shamt;
    assign alu_sel     = r_sel;
`ifdef ALU_ARB_TIMEOUT_EN
    assign timeout     = r_timeout;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios plus randomized
// transactions checked against a transaction-level round-robin model.
module tb_alu_arbiter;

    localparam int N  = 4;
    localparam int TO = 16;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req_valid, req_ready, rsp_valid, rsp_ready;
    logic [N*5-1:0]  req_op, req_shamt;
    logic [N*32-1:0] req_a, req_b;
    logic [31:0]     rsp_data, alu_number1, alu_number2, alu_result;
    logic            rsp_err;
    logic [4:0]      alu_shamt, alu_sel;
`ifdef ALU_ARB_TIMEOUT_EN
    logic            timeout;
`endif

    always #5 clk = ~clk;

    alu_arbiter #(.NUM_REQ(N), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b), .req_shamt(req_shamt),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_err(rsp_err),
        .alu_number1(alu_number1), .alu_number2(alu_number2),
        .alu_shamt(alu_shamt), .alu_sel(alu_sel), .alu_result(alu_result)
`ifdef ALU_ARB_TIMEOUT_EN
        , .timeout(timeout)
`endif
    );

    // ---------------- environment ALU stub ----------------
    function automatic logic [31:0] clz32(input logic [31:0] x);
        int n;
        bit found;
        n = 0;
        found = 1'b0;
        for (int i = 31; i >= 0; i--) begin
            if (!found && x[i]) found = 1'b1;
            else if (!found) n++;
        end
        return 32'(n);
    endfunction

    function automatic logic [31:0] alu_fn(input logic [4:0] op, input logic [31:0] a,
                                           input logic [31:0] b, input logic [4:0] sh);
        case (op)
            5'd0:    return a + b;
            5'd1:    return a - b;
            5'd2:    return a & b;
            5'd3:    return a | b;
            5'd4:    return a ^ b;
            5'd5:    return a << sh;
            5'd6:    return a >> sh;
            5'd14:   return clz32(a);
            5'd16:   return 32'($countones(a));
            default: return a + b + 32'(op);
        endcase
    endfunction

    always_comb alu_result = alu_fn(alu_sel, alu_number1, alu_number2, alu_shamt);

    // ---------------- requester state and model ----------------
    logic [N-1:0] m_v;
    logic [4:0]   m_op [N];
    logic [31:0]  m_a  [N];
    logic [31:0]  m_b  [N];
    logic [4:0]   m_sh [N];
    int           m_last;
    int           n_checks = 0;
    int           n_pass   = 0;

    function automatic logic [N-1:0] oh(input int g);
        logic [N-1:0] v;
        v = '0;
        if (g >= 0) v[g] = 1'b1;
        return v;
    endfunction

    // Round-robin rule: first valid requester after the last grant, wrapping.
    function automatic int model_pick();
        for (int k = 1; k <= N; k++) begin
            if (m_v[(m_last + k) % N]) return (m_last + k) % N;
        end
        return -1;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            req_valid[i]         = m_v[i];
            req_op[i*5 +: 5]     = m_op[i];
            req_a[i*32 +: 32]    = m_a[i];
            req_b[i*32 +: 32]    = m_b[i];
            req_shamt[i*5 +: 5]  = m_sh[i];
        end
    endtask

    task automatic set_req(input int g, input logic [4:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [4:0] sh);
        m_v[g] = 1'b1; m_op[g] = op; m_a[g] = a; m_b[g] = b; m_sh[g] = sh;
    endtask

    task automatic new_payload(input int g);
        set_req(g, 5'($urandom_range(0, 20)), $urandom, $urandom, 5'($urandom_range(0, 31)));
    endtask

    // Called and returns at posedge+1.
    task automatic do_reset();
        rst_n = 1'b0;
        rsp_ready = '0;
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        m_last = N - 1;
    endtask

    // One transaction starting in an IDLE cycle (posedge+1). mode: 0 granted
    // requester drops, 1 re-requests same payload, 2 random.
    task automatic do_txn(input int rdelay, input logic [N-1:0] add_mask, input int mode);
        int g;
        logic [4:0] op;
        logic [31:0] a, b, exp;
        logic [4:0] sh;
        logic err;
        drive();
        g = model_pick();
        #4;
        check("grant", 64'(req_ready), 64'(oh(g)));
        if (g < 0) begin
            @(posedge clk); #1;
            return;
        end
        op = m_op[g]; a = m_a[g]; b = m_b[g]; sh = m_sh[g];
        err = (op > 5'd16);
        exp = err ? 32'd0 : alu_fn(op, a, b, sh);
        m_last = g;
        @(posedge clk); #1;
        if (mode == 0) m_v[g] = 1'b0;
        else if (mode == 2) begin
            if ($urandom_range(0, 1) == 1) new_payload(g);
            else m_v[g] = 1'b0;
        end
        for (int i = 0; i < N; i++) if (add_mask[i] && !m_v[i]) new_payload(i);
        drive();
        rsp_ready = '0;
        #4;
        check("exec_rsp_valid", 64'(rsp_valid), 64'd0);
        check("exec_ready", 64'(req_ready), 64'd0);
        check("exec_alu_sel", 64'(alu_sel), 64'(op));
        check("exec_alu_ops", {alu_number1, alu_number2}, {a, b});
        check("exec_alu_shamt", 64'(alu_shamt), 64'(sh));
        @(posedge clk); #1;
        for (int d = 0; d <= rdelay; d++) begin
            rsp_ready = (d == rdelay) ? oh(g) : ~oh(g);
            #4;
            check("resp_valid", 64'(rsp_valid), 64'(oh(g)));
            check("resp_data", {31'd0, rsp_err, rsp_data}, {31'd0, err, exp});
            check("resp_no_grant", 64'(req_ready), 64'd0);
            @(posedge clk); #1;
        end
        rsp_ready = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        rsp_ready = '0;
        m_v = '0;
        for (int i = 0; i < N; i++) begin
            m_op[i] = 5'd0; m_a[i] = 32'd0; m_b[i] = 32'd0; m_sh[i] = 5'd0;
        end
        drive();
        @(posedge clk); #1;
        do_reset();

        // Reset state, no requests.
        #4;
        check("rst_req_ready", 64'(req_ready), 64'd0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_rsp", {31'd0, rsp_err, rsp_data}, 64'd0);
        check("rst_alu_ops", {alu_number1, alu_number2}, 64'd0);
        check("rst_alu_sel_shamt", {54'd0, alu_sel, alu_shamt}, 64'd0);
        @(posedge clk); #1;

        // ADD 5+7 from requester 0.
        set_req(0, 5'd0, 32'd5, 32'd7, 5'd0);
        do_txn(0, '0, 0);

        // All four requesting CPOP(0xFF): grants 0,1,2,3,0, three cycles apart.
        do_reset();
        for (int i = 0; i < N; i++) set_req(i, 5'd16, 32'hFF, 32'd0, 5'd0);
        repeat (5) do_txn(0, '0, 1);

        // CLZ(0) from requester 2 with response back-pressure; others arrive late.
        m_v = '0;
        set_req(2, 5'd14, 32'd0, 32'd0, 5'd0);
        do_txn(5, 4'b1011, 0);
        repeat (3) do_txn(0, '0, 0);

        // Illegal opcode 20 from requester 1.
        m_v = '0;
        set_req(1, 5'd20, 32'd1, 32'd1, 5'd0);
        do_txn(0, '0, 0);

        // Reset during EXEC of a requester-3 operation.
        do_reset();
        m_v = '0;
        set_req(3, 5'd5, 32'h1234, 32'h55, 5'd3);
        drive();
        #4;
        check("mid_rst_grant3", 64'(req_ready), 64'(oh(3)));
        @(posedge clk); #1;
        for (int i = 0; i < N; i++) set_req(i, 5'd16, 32'hFF, 32'd0, 5'd0);
        drive();
        rst_n = 1'b0;
        #1;
        check("mid_rst_ready", 64'(req_ready), 64'd0);
        check("mid_rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("mid_rst_rsp", {31'd0, rsp_err, rsp_data}, 64'd0);
        check("mid_rst_alu_ops", {alu_number1, alu_number2}, 64'd0);
        check("mid_rst_alu_sel_shamt", {54'd0, alu_sel, alu_shamt}, 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        m_last = N - 1;
        do_txn(0, '0, 0);

`ifdef ALU_ARB_TIMEOUT_EN
        // Watchdog drops an unacknowledged response and moves on.
        do_reset();
        m_v = '0;
        set_req(0, 5'd0, 32'd1, 32'd2, 5'd0);
        set_req(1, 5'd0, 32'd3, 32'd4, 5'd0);
        drive();
        #4;
        check("to_grant0", 64'(req_ready), 64'(oh(0)));
        @(posedge clk); #1;
        m_v[0] = 1'b0;
        drive();
        @(posedge clk); #1;
        for (int d = 0; d < TO; d++) begin
            #4;
            check("to_rsp_valid", 64'(rsp_valid), 64'(oh(0)));
            check("to_no_pulse", 64'(timeout), 64'd0);
            @(posedge clk); #1;
        end
        #4;
        check("to_pulse", 64'(timeout), 64'd1);
        check("to_dropped", 64'(rsp_valid), 64'd0);
        check("to_next_grant", 64'(req_ready), 64'(oh(1)));
        @(posedge clk); #1;
        m_v[1] = 1'b0;
        drive();
        m_last = 1;
        #4;
        check("to_pulse_end", 64'(timeout), 64'd0);
        @(posedge clk); #1;
        rsp_ready = oh(1);
        #4;
        check("to_rsp1", {31'd0, rsp_err, rsp_data}, 64'd7);
        @(posedge clk); #1;
        rsp_ready = '0;
`endif

        // Randomized transactions against the model.
        for (int t = 0; t < 30; t++) begin
            if (m_v == '0) new_payload($urandom_range(0, N - 1));
            do_txn($urandom_range(0, 3), N'($urandom_range(0, 15)), 2);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
